breathe_pwm: RTL and testbench

BREATHE_PWM -- requirements
Module: breathe_pwm

---
 rtl/breathe_pwm_pkg.sv | 21 ++
 rtl/breathe_pwm_compare.sv | 42 ++++
 rtl/breathe_pwm.sv | 124 ++++++++++++
 tb/tb_breathe_pwm.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/breathe_pwm_pkg.sv
// Shared definitions for the 8-bit counter family and the breathing-LED
// sequencer built on top of it.
//   CNT_W   : width of the upstream free-running counter and of LEVEL/DUTY
//   EXT_W   : signed working width for saturating LEVEL arithmetic
//   phase_t : sequencer phase encodings driven out on PHASE
package breathe_pwm_pkg;

  localparam int CNT_W = 8;
  localparam int EXT_W = CNT_W + 2;

  typedef logic [CNT_W-1:0]        cnt_t;
  typedef logic signed [EXT_W-1:0] ext_t;

  typedef enum logic [1:0] {
    RAMP_UP   = 2'd0,
    HOLD_HI   = 2'd1,
    RAMP_DOWN = 2'd2,
    HOLD_LO   = 2'd3
  } phase_t;

endpackage

// File: rtl/breathe_pwm_compare.sv
// DUTY shadow register and PWM comparator.
// DUTY is reloaded from LEVEL on every WRAP so the duty cycle only ever
// changes at a counter period boundary. PWM is registered: it reflects the
// CNT value sampled one edge earlier.
//   CLK   : clock, rising edge
//   RESET : synchronous active-high reset (clears DUTY and PWM)
//   CNT   : free-running 8-bit count
//   WRAP  : one-cycle pulse while CNT is at its terminal count
//   LEVEL : brightness to adopt as DUTY at the next WRAP
//   PWM   : registered (CNT < DUTY)
module pwm_compare
  import breathe_pwm_pkg::*;
(
  input  logic             CLK,
  input  logic             RESET,
  input  logic [CNT_W-1:0] CNT,
  input  logic             WRAP,
  input  logic [CNT_W-1:0] LEVEL,
  output logic             PWM
);

  cnt_t duty_p0;
  logic pwm_p1;

  // Stage 0 -> 1: shadow DUTY at the period boundary, then compare.
  // On the WRAP cycle CNT is at its terminal count, so the compare there
  // is always low and DUTY=255 yields 255 high counts out of 256.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      duty_p0 <= '0;
      pwm_p1  <= 1'b0;
    end else begin
      if (WRAP) begin
        duty_p0 <= LEVEL;
      end
      pwm_p1 <= (CNT < duty_p0);
    end
  end

  assign PWM = pwm_p1;

endmodule

// File: rtl/breathe_pwm.sv
// Breathing-LED brightness sequencer.
// Ramps LEVEL up by STEP per counter wrap to full scale, holds for
// HOLD_PERIODS wraps, ramps down to zero, holds again, and repeats.
// The sequencer only moves on step events (WRAP and EN both high).
//   CLK   : clock, rising edge
//   RESET : synchronous active-high reset, dominant over WRAP/EN
//   EN    : allows the sequencer to advance
//   CNT   : free-running count from the upstream counter
//   WRAP  : counter wrap pulse
//   PWM   : registered LED drive
//   LEVEL : current brightness
//   PHASE : 0 RAMP_UP, 1 HOLD_HI, 2 RAMP_DOWN, 3 HOLD_LO
module breathe_pwm
  import breathe_pwm_pkg::*;
#(
  parameter int STEP         = 1,
  parameter int HOLD_PERIODS = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             EN,
  input  logic [CNT_W-1:0] CNT,
  input  logic             WRAP,
  output logic             PWM,
  output logic [CNT_W-1:0] LEVEL,
  output logic [1:0]       PHASE
);

  localparam ext_t STEP_S    = ext_t'(STEP);
  localparam cnt_t HOLD_LAST = cnt_t'(HOLD_PERIODS);
  localparam cnt_t LEVEL_MAX = '1;

  phase_t phase, phase_nxt;
  cnt_t   level, level_nxt;
  cnt_t   hold,  hold_nxt;

  // Widened signed arithmetic so overflow/underflow are visible before
  // clamping to the LEVEL range.
  function automatic cnt_t sat_inc(input cnt_t a);
    ext_t s;
    s = ext_t'({2'b00, a}) + STEP_S;
    if (s > ext_t'(LEVEL_MAX)) begin
      return LEVEL_MAX;
    end
    return s[CNT_W-1:0];
  endfunction

  function automatic cnt_t sat_dec(input cnt_t a);
    ext_t s;
    s = ext_t'({2'b00, a}) - STEP_S;
    if (s < 0) begin
      return '0;
    end
    return s[CNT_W-1:0];
  endfunction

  always_comb begin
    phase_nxt = phase;
    level_nxt = level;
    hold_nxt  = hold;
    if (WRAP && EN) begin
      case (phase)
        RAMP_UP: begin
          level_nxt = sat_inc(level);
          if (level_nxt == LEVEL_MAX) begin
            phase_nxt = HOLD_HI;
            hold_nxt  = '0;
          end
        end
        HOLD_HI: begin
          hold_nxt = hold + 1'b1;
          if (hold_nxt == HOLD_LAST) begin
            phase_nxt = RAMP_DOWN;
            hold_nxt  = '0;
          end
        end
        RAMP_DOWN: begin
          level_nxt = sat_dec(level);
          if (level_nxt == '0) begin
            phase_nxt = HOLD_LO;
            hold_nxt  = '0;
          end
        end
        HOLD_LO: begin
          hold_nxt = hold + 1'b1;
          if (hold_nxt == HOLD_LAST) begin
            phase_nxt = RAMP_UP;
            hold_nxt  = '0;
          end
        end
        default: begin
          phase_nxt = RAMP_UP;
        end
      endcase
    end
  end

  // Sequencer state register.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      phase <= RAMP_UP;
      level <= '0;
      hold  <= '0;
    end else begin
      phase <= phase_nxt;
      level <= level_nxt;
      hold  <= hold_nxt;
    end
  end

  // The comparator takes the registered (pre-update) level at WRAP.
  pwm_compare u_cmp (
    .CLK   (CLK),
    .RESET (RESET),
    .CNT   (CNT),
    .WRAP  (WRAP),
    .LEVEL (level),
    .PWM   (PWM)
  );

  assign LEVEL = level;
  assign PHASE = phase;

endmodule

// File: tb/tb_breathe_pwm.sv
// Scoreboard bench for breathe_pwm. Stimulus pushes expected values; the
// negedge monitor pops and compares them against the outputs of two
// instances (STEP=1 and STEP=100), and accumulates PWM statistics over
// measurement windows.
module tb_breathe_pwm;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       wrap;
  logic [7:0] cnt;

  logic       pwm_a,   pwm_b;
  logic [7:0] level_a, level_b;
  logic [1:0] phase_a, phase_b;

  always #5 clk = ~clk;

  breathe_pwm u_a (
    .CLK(clk), .RESET(rst), .EN(en), .CNT(cnt), .WRAP(wrap),
    .PWM(pwm_a), .LEVEL(level_a), .PHASE(phase_a)
  );

  breathe_pwm #(.STEP(100), .HOLD_PERIODS(16)) u_b (
    .CLK(clk), .RESET(rst), .EN(en), .CNT(cnt), .WRAP(wrap),
    .PWM(pwm_b), .LEVEL(level_b), .PHASE(phase_b)
  );

  localparam int S_LEVEL_A = 0;
  localparam int S_PHASE_A = 1;
  localparam int S_PWM_A   = 2;
  localparam int S_LEVEL_B = 3;
  localparam int S_PHASE_B = 4;
  localparam int S_HI_CNT  = 5;
  localparam int S_RISES   = 6;

  typedef struct {
    string name;
    int    sig;
    int    val;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   act;
  int   compared   = 0;
  int   mismatched = 0;

  logic meas     = 1'b0;
  logic prev_pwm = 1'b0;
  int   hi_cnt   = 0;
  int   rises    = 0;

  function automatic int probe(input int sig);
    case (sig)
      S_LEVEL_A: return int'(level_a);
      S_PHASE_A: return int'(phase_a);
      S_PWM_A:   return int'(pwm_a);
      S_LEVEL_B: return int'(level_b);
      S_PHASE_B: return int'(phase_b);
      S_HI_CNT:  return hi_cnt;
      S_RISES:   return rises;
      default:   return -1;
    endcase
  endfunction

  // Monitor: accumulate window stats, check pending expectations, then
  // clear stats while no window is open.
  always @(negedge clk) begin
    if (meas) begin
      if (pwm_a) hi_cnt++;
      if (pwm_a && !prev_pwm) rises++;
    end
    prev_pwm = pwm_a;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      act = probe(e.sig);
      compared++;
      if (act != e.val) begin
        mismatched++;
        $display("FAIL %s: got %0d, expected %0d", e.name, act, e.val);
      end
    end
    if (!meas) begin
      hi_cnt = 0;
      rises  = 0;
    end
  end

  task automatic chk(input string name, input int sig, input int val);
    exp_t x;
    x.name = name;
    x.sig  = sig;
    x.val  = val;
    sb.push_back(x);
  endtask

  // One edge of a free-running counter; WRAP accompanies CNT=255.
  task automatic tick();
    @(posedge clk);
    #1;
    cnt  = cnt + 8'd1;
    wrap = (cnt == 8'hFF);
  endtask

  // Shortened counter period: terminal count with WRAP, then count 0.
  task automatic wraps(input int n);
    repeat (n) begin
      cnt  = 8'hFF;
      wrap = 1'b1;
      @(posedge clk);
      #1;
      cnt  = 8'h00;
      wrap = 1'b0;
      @(posedge clk);
      #1;
      cnt  = 8'h01;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst  = 1'b1;
    en   = 1'b0;
    cnt  = 8'h00;
    wrap = 1'b0;
    tick();
    chk("rst_level", S_LEVEL_A, 0);
    chk("rst_phase", S_PHASE_A, 0);
    chk("rst_pwm",   S_PWM_A,   0);

    // Full ramp up with STEP=1, then both hold phases and the ramp down.
    rst = 1'b0;
    en  = 1'b1;
    wraps(254);
    chk("ramp254_level", S_LEVEL_A, 254);
    chk("ramp254_phase", S_PHASE_A, 0);
    wraps(1);
    chk("ramp255_level", S_LEVEL_A, 255);
    chk("ramp255_phase", S_PHASE_A, 1);
    wraps(15);
    chk("holdhi15_phase", S_PHASE_A, 1);
    chk("holdhi15_level", S_LEVEL_A, 255);
    wraps(1);
    chk("holdhi16_phase", S_PHASE_A, 2);
    chk("holdhi16_level", S_LEVEL_A, 255);
    wraps(1);
    chk("down1_level", S_LEVEL_A, 254);
    chk("down1_phase", S_PHASE_A, 2);
    wraps(253);
    chk("down254_level", S_LEVEL_A, 1);
    wraps(1);
    chk("down255_level", S_LEVEL_A, 0);
    chk("down255_phase", S_PHASE_A, 3);
    wraps(15);
    chk("holdlo15_phase", S_PHASE_A, 3);
    wraps(1);
    chk("holdlo16_phase", S_PHASE_A, 0);
    chk("holdlo16_level", S_LEVEL_A, 0);
    wraps(1);
    chk("up_again_level", S_LEVEL_A, 1);

    // Duty 64: ramp to 64, freeze, load DUTY and measure one full period.
    wraps(63);
    en = 1'b0;
    wraps(1);
    chk("duty_level", S_LEVEL_A, 64);
    meas = 1'b1;
    chk("duty_cnt0", S_PWM_A, 1);
    repeat (63) tick();
    chk("duty_cnt63", S_PWM_A, 1);
    tick();
    chk("duty_cnt64", S_PWM_A, 0);
    repeat (191) tick();
    chk("duty_cnt255", S_PWM_A, 0);
    meas = 1'b0;
    chk("duty64_high", S_HI_CNT, 64);
    chk("duty64_runs", S_RISES,  1);

    // Freeze at LEVEL=40 for 1000 cycles.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    en  = 1'b1;
    wraps(40);
    chk("frz_start_level", S_LEVEL_A, 40);
    en = 1'b0;
    repeat (1000) tick();
    chk("frz_level", S_LEVEL_A, 40);
    chk("frz_phase", S_PHASE_A, 0);
    for (int i = 0; i < 256 && cnt != 8'd1; i++) tick();
    meas = 1'b1;
    repeat (255) tick();
    meas = 1'b0;
    chk("frz_high", S_HI_CNT, 40);
    chk("frz_runs", S_RISES,  1);
    en = 1'b1;
    repeat (255) tick();
    chk("frz_pre_wrap_level", S_LEVEL_A, 40);
    tick();
    chk("frz_resume_level", S_LEVEL_A, 41);
    chk("frz_resume_phase", S_PHASE_A, 0);

    // Walk to LEVEL=137 in RAMP_DOWN, then reset mid-ramp.
    wraps(214);
    chk("r_hold_phase", S_PHASE_A, 1);
    wraps(16);
    chk("r_down_phase", S_PHASE_A, 2);
    wraps(118);
    chk("r137_level", S_LEVEL_A, 137);
    chk("r137_phase", S_PHASE_A, 2);
    chk("r137_pwm",   S_PWM_A,   1);
    rst = 1'b1;
    tick();
    chk("r_level", S_LEVEL_A, 0);
    chk("r_phase", S_PHASE_A, 0);
    chk("r_pwm",   S_PWM_A,   0);
    tick();
    rst  = 1'b0;
    meas = 1'b1;
    repeat (256) tick();
    meas = 1'b0;
    chk("r_pwm_high", S_HI_CNT, 0);
    chk("r_after_level", S_LEVEL_A, 1);

    // Saturation with STEP=100.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    en  = 1'b1;
    chk("sat_l0", S_LEVEL_B, 0);
    wraps(1);
    chk("sat_l100", S_LEVEL_B, 100);
    wraps(1);
    chk("sat_l200", S_LEVEL_B, 200);
    wraps(1);
    chk("sat_l255", S_LEVEL_B, 255);
    chk("sat_hold_phase", S_PHASE_B, 1);
    wraps(16);
    chk("sat_down_phase", S_PHASE_B, 2);
    wraps(1);
    chk("sat_l155", S_LEVEL_B, 155);
    wraps(1);
    chk("sat_l55", S_LEVEL_B, 55);
    wraps(1);
    chk("sat_l0_down", S_LEVEL_B, 0);
    chk("sat_holdlo_phase", S_PHASE_B, 3);

    @(negedge clk);
    @(posedge clk);
    #1;
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
